// File: rtl/hbm_read_gather_pkg.sv
// rtl/hbm_read_gather_pkg.sv - shared types and constants for the HBM read gather block
package hbm_read_gather_pkg;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'b001,
    ST_ISSUE = 3'b010,
    ST_WAIT  = 3'b100
  } state_t;

  localparam int BEAT_BYTES  = 32;
  localparam int WORD_BYTES  = 64;
  localparam int BOUNDARY_4K = 4096;

  localparam logic [2:0] ARSIZE_32B = 3'b101;
  localparam logic [1:0] BURST_INCR = 2'b01;
  localparam logic [1:0] RESP_OKAY  = 2'b00;

endpackage

// File: rtl/hbm_rd_pack.sv
// rtl/hbm_rd_pack.sv - packs pairs of 256-bit beats into 512-bit words, first beat low
module hbm_rd_pack (
  input  logic         hbm_clk,
  input  logic         hbm_reset,
  input  logic         clear,
  input  logic         beat_valid,
  input  logic [255:0] beat_data,
  output logic [511:0] back_data,
  output logic         back_valid
);

  logic         phase;
  logic [255:0] low_half;

  always_ff @(posedge hbm_clk or posedge hbm_reset) begin
    if (hbm_reset) begin
      phase      <= 1'b0;
      low_half   <= '0;
      back_data  <= '0;
      back_valid <= 1'b0;
    end else begin
      back_valid <= 1'b0;
      if (clear) begin
        phase <= 1'b0;
      end else if (beat_valid) begin
        if (!phase) begin
          low_half <= beat_data;
          phase    <= 1'b1;
        end else begin
          back_data  <= {beat_data, low_half};
          back_valid <= 1'b1;
          phase      <= 1'b0;
        end
      end
    end
  end

endmodule

// File: rtl/hbm_read_gather.sv
// rtl/hbm_read_gather.sv - AXI4 read gatherer feeding 512-bit words to the send-back FIFO
// Optional debug counters on status_reg when HBM_RD_STATUS_EN is defined.
module hbm_read_gather
  import hbm_read_gather_pkg::*;
#(
  parameter int ADDR_W    = 33,
  parameter int BURST_LEN = 16,
  parameter int MAX_OUT   = 4
) (
  input  logic               hbm_clk,
  input  logic               hbm_reset,
  input  logic               start,
  input  logic [63:0]        addr_x,
  input  logic [31:0]        data_length,
  output logic [ADDR_W-1:0]  m_axi_araddr,
  output logic [7:0]         m_axi_arlen,
  output logic [2:0]         m_axi_arsize,
  output logic [1:0]         m_axi_arburst,
  output logic               m_axi_arvalid,
  input  logic               m_axi_arready,
  input  logic [255:0]       m_axi_rdata,
  input  logic [1:0]         m_axi_rresp,
  input  logic               m_axi_rlast,
  input  logic               m_axi_rvalid,
  output logic               m_axi_rready,
  output logic [511:0]       back_data,
  output logic               back_valid,
  input  logic               almost_full,
  output logic               busy,
  output logic               done,
  output logic               error,
  output logic [7:0][31:0]   status_reg
);

  localparam int OUT_W = $clog2(MAX_OUT + 1);

  state_t             state;
  logic               start_d0, start_d1;
  logic [ADDR_W-1:0]  cur_addr;
  logic [31:0]        rem;
  logic [OUT_W-1:0]   out_cnt, out_nxt;
  logic               launch, ar_acc, r_acc, r_last_acc, r_err, can_issue;
  logic [31:0]        beats_rem, burst_bytes;
  logic [12:0]        bytes_4k;
  logic [7:0]         burst_beats;

  assign launch     = start_d0 & ~start_d1;
  assign ar_acc     = m_axi_arvalid & m_axi_arready;
  assign r_acc      = m_axi_rvalid & m_axi_rready;
  assign r_last_acc = r_acc & m_axi_rlast;
  assign r_err      = r_acc & (m_axi_rresp != RESP_OKAY);

  assign m_axi_arsize  = ARSIZE_32B;
  assign m_axi_arburst = BURST_INCR;
  assign m_axi_rready  = busy;

  // Burst never runs past the remaining bytes, BURST_LEN or the next 4 KB line.
  assign beats_rem   = rem >> $clog2(BEAT_BYTES);
  assign bytes_4k    = 13'(BOUNDARY_4K) - {1'b0, cur_addr[11:0]};
  assign burst_bytes = {19'd0, burst_beats, 5'd0};

  always_comb begin
    burst_beats = 8'(BURST_LEN);
    if (bytes_4k[12:5] < burst_beats) burst_beats = bytes_4k[12:5];
    if (beats_rem < {24'd0, burst_beats}) burst_beats = beats_rem[7:0];
  end

  always_comb begin
    out_nxt = out_cnt;
    if (ar_acc && !r_last_acc) out_nxt = out_cnt + OUT_W'(1);
    else if (!ar_acc && r_last_acc) out_nxt = out_cnt - OUT_W'(1);
  end

  // A pending AR must be accepted before the next one is presented.
  assign can_issue = (rem != '0) && !almost_full && (!m_axi_arvalid || ar_acc)
                     && (out_nxt < OUT_W'(MAX_OUT));

  always_ff @(posedge hbm_clk or posedge hbm_reset) begin
    if (hbm_reset) begin
      state         <= ST_IDLE;
      start_d0      <= 1'b0;
      start_d1      <= 1'b0;
      cur_addr      <= '0;
      rem           <= '0;
      out_cnt       <= '0;
      m_axi_araddr  <= '0;
      m_axi_arlen   <= '0;
      m_axi_arvalid <= 1'b0;
      busy          <= 1'b0;
      done          <= 1'b0;
      error         <= 1'b0;
    end else begin
      start_d0 <= start;
      start_d1 <= start_d0;
      done     <= 1'b0;
      out_cnt  <= out_nxt;
      if (ar_acc) m_axi_arvalid <= 1'b0;
      if (r_err) error <= 1'b1;
      case (state)
        ST_IDLE: begin
          if (launch) begin
            cur_addr <= addr_x[ADDR_W-1:0];
            rem      <= data_length;
            error    <= 1'b0;
            if (data_length == '0) begin
              done <= 1'b1;
            end else begin
              busy  <= 1'b1;
              state <= ST_ISSUE;
            end
          end
        end
        ST_ISSUE: begin
          if (can_issue) begin
            m_axi_arvalid <= 1'b1;
            m_axi_araddr  <= cur_addr;
            m_axi_arlen   <= burst_beats - 8'd1;
            cur_addr      <= cur_addr + ADDR_W'(burst_bytes);
            rem           <= rem - burst_bytes;
          end
          if (ar_acc && rem == '0) state <= ST_WAIT;
        end
        ST_WAIT: begin
          if (out_cnt == '0) begin
            done  <= 1'b1;
            busy  <= 1'b0;
            state <= ST_IDLE;
          end
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

  hbm_rd_pack u_pack (
    .hbm_clk    (hbm_clk),
    .hbm_reset  (hbm_reset),
    .clear      (launch && state == ST_IDLE),
    .beat_valid (r_acc),
    .beat_data  (m_axi_rdata),
    .back_data  (back_data),
    .back_valid (back_valid)
  );

`ifdef HBM_RD_STATUS_EN
  logic [31:0] cnt_ar, cnt_beat, cnt_word, cnt_stall, cnt_err;

  always_ff @(posedge hbm_clk or posedge hbm_reset) begin
    if (hbm_reset) begin
      cnt_ar    <= '0;
      cnt_beat  <= '0;
      cnt_word  <= '0;
      cnt_stall <= '0;
      cnt_err   <= '0;
    end else if (launch && state == ST_IDLE) begin
      cnt_ar    <= '0;
      cnt_beat  <= '0;
      cnt_word  <= '0;
      cnt_stall <= '0;
      cnt_err   <= '0;
    end else begin
      if (ar_acc) cnt_ar <= cnt_ar + 32'd1;
      if (r_acc) cnt_beat <= cnt_beat + 32'd1;
      if (back_valid) cnt_word <= cnt_word + 32'd1;
      if (state == ST_ISSUE && almost_full && rem != '0) cnt_stall <= cnt_stall + 32'd1;
      if (r_err) cnt_err <= cnt_err + 32'd1;
    end
  end

  assign status_reg = {32'd0, 32'd0, cnt_err, cnt_stall, {29'd0, state}, cnt_word, cnt_beat, cnt_ar};
`else
  assign status_reg = '0;
`endif

  logic unused_bits;
  assign unused_bits = &{1'b0, addr_x[63:ADDR_W], bytes_4k[4:0]};

endmodule

// File: tb/tb_hbm_read_gather.sv
// tb/tb_hbm_read_gather.sv - randomized scoreboard bench for hbm_read_gather
module tb_hbm_read_gather;

  logic               hbm_clk = 1'b0;
  logic               hbm_reset;
  logic               start;
  logic [63:0]        addr_x;
  logic [31:0]        data_length;
  logic [32:0]        m_axi_araddr;
  logic [7:0]         m_axi_arlen;
  logic [2:0]         m_axi_arsize;
  logic [1:0]         m_axi_arburst;
  logic               m_axi_arvalid, m_axi_arready;
  logic [255:0]       m_axi_rdata;
  logic [1:0]         m_axi_rresp;
  logic               m_axi_rlast, m_axi_rvalid, m_axi_rready;
  logic [511:0]       back_data;
  logic               back_valid, almost_full, busy, done, error;
  logic [7:0][31:0]   status_reg;

  always #5 hbm_clk = ~hbm_clk;

  hbm_read_gather dut (
    .hbm_clk(hbm_clk), .hbm_reset(hbm_reset), .start(start), .addr_x(addr_x),
    .data_length(data_length), .m_axi_araddr(m_axi_araddr), .m_axi_arlen(m_axi_arlen),
    .m_axi_arsize(m_axi_arsize), .m_axi_arburst(m_axi_arburst), .m_axi_arvalid(m_axi_arvalid),
    .m_axi_arready(m_axi_arready), .m_axi_rdata(m_axi_rdata), .m_axi_rresp(m_axi_rresp),
    .m_axi_rlast(m_axi_rlast), .m_axi_rvalid(m_axi_rvalid), .m_axi_rready(m_axi_rready),
    .back_data(back_data), .back_valid(back_valid), .almost_full(almost_full),
    .busy(busy), .done(done), .error(error), .status_reg(status_reg)
  );

  int ntests = 0, nfail = 0, cyc = 0;
  int ar_gap = 0, r_gap = 0, r_delay = 0, job_len = 0;
  int n_ar_acc = 0, max_out_m = 0;
  logic ar_rdy_rand = 1'b1, ar_block = 1'b0, af_force = 1'b0, af_rnd = 1'b0, af_rand_en = 1'b0;
  logic [32:0] err_addr = '1;
  logic [511:0] exp_words[$];
  logic [40:0]  exp_ar[$];

  assign m_axi_arready = ar_rdy_rand & ~ar_block;
  assign almost_full   = af_force | af_rnd;

  always @(posedge hbm_clk) cyc <= cyc + 1;

  task automatic check_eq(input string nm, input logic [511:0] act, input logic [511:0] exp);
    ntests++;
    if (act !== exp) begin
      nfail++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  // Deterministic memory contents: every 32-byte beat depends on its address.
  function automatic logic [255:0] mem_beat(input logic [32:0] a);
    logic [255:0] d;
    for (int i = 0; i < 8; i++) d[i*32 +: 32] = a[31:0] * 32'h9E3779B1 + 32'(i) + {a[32], 31'd0};
    return d;
  endfunction

  task automatic push_exp(input logic [32:0] a, input int len);
    logic [32:0] ad;
    int rem, b, bb;
    ad = a;
    rem = len;
    while (rem > 0) begin
      b = rem / 32;
      if (b > 16) b = 16;
      bb = (4096 - int'(ad[11:0])) / 32;
      if (b > bb) b = bb;
      exp_ar.push_back({ad, 8'(b - 1)});
      ad += 33'(b * 32);
      rem -= b * 32;
    end
    for (int k = 0; k < len / 64; k++)
      exp_words.push_back({mem_beat(a + 33'(k * 64 + 32)), mem_beat(a + 33'(k * 64))});
  endtask

  // AXI read slave: ARs queue up, R beats follow after r_delay cycles with random gaps.
  initial begin : slave
    logic [32:0] q_addr[$];
    logic [7:0]  q_len[$];
    int          q_cyc[$];
    logic        ar_fire, r_fire;
    logic [32:0] a_addr, a;
    logic [7:0]  a_len;
    int          beat;
    beat = 0;
    m_axi_rvalid = 1'b0; m_axi_rlast = 1'b0; m_axi_rresp = 2'b00; m_axi_rdata = '0;
    forever begin
      @(negedge hbm_clk);
      ar_fire = m_axi_arvalid && m_axi_arready;
      r_fire  = m_axi_rvalid && m_axi_rready;
      a_addr  = m_axi_araddr;
      a_len   = m_axi_arlen;
      @(posedge hbm_clk);
      #1;
      if (hbm_reset) begin
        q_addr.delete(); q_len.delete(); q_cyc.delete();
        beat = 0;
        m_axi_rvalid = 1'b0;
        continue;
      end
      if (ar_fire) begin
        q_addr.push_back(a_addr); q_len.push_back(a_len); q_cyc.push_back(cyc);
      end
      if (r_fire && q_addr.size() > 0) begin
        if (beat == int'(q_len[0])) begin
          void'(q_addr.pop_front()); void'(q_len.pop_front()); void'(q_cyc.pop_front());
          beat = 0;
        end else beat++;
      end
      m_axi_rvalid = 1'b0;
      if (q_addr.size() > 0 && cyc >= q_cyc[0] + r_delay && $urandom_range(0, 99) >= r_gap) begin
        a = q_addr[0] + 33'(beat * 32);
        m_axi_rdata  = mem_beat(a);
        m_axi_rlast  = (beat == int'(q_len[0]));
        m_axi_rresp  = (a == err_addr) ? 2'b10 : 2'b00;
        m_axi_rvalid = 1'b1;
      end
      ar_rdy_rand = ($urandom_range(0, 99) >= ar_gap);
      af_rnd = af_rand_en && ($urandom_range(0, 3) == 0);
    end
  end

  // Monitor: scoreboard pops plus protocol checks on every cycle.
  initial begin : monitor
    logic prev_arv, prev_acc, prev_af, prev_bv, new_ar, ar_fire, rl_fire;
    logic [40:0] prev_pay, e;
    int out_m;
    prev_arv = 0; prev_acc = 0; prev_af = 0; prev_bv = 0; out_m = 0; prev_pay = '0;
    forever begin
      @(negedge hbm_clk);
      if (hbm_reset) begin
        prev_arv = 0; prev_acc = 0; prev_af = 0; prev_bv = 0; out_m = 0;
        continue;
      end
      ar_fire = m_axi_arvalid && m_axi_arready;
      rl_fire = m_axi_rvalid && m_axi_rready && m_axi_rlast;
      if (back_valid) begin
        check_eq("word_pending", 512'(exp_words.size() != 0), 512'(1));
        if (exp_words.size() != 0) check_eq("word_data", back_data, exp_words.pop_front());
      end
      new_ar = m_axi_arvalid && (!prev_arv || prev_acc);
      if (new_ar) check_eq("ar_during_almost_full", 512'(prev_af), 512'(0));
      if (m_axi_arvalid && prev_arv && !prev_acc)
        check_eq("ar_stable", 512'({m_axi_araddr, m_axi_arlen}), 512'(prev_pay));
      if (done && job_len != 0) check_eq("done_after_last_word", 512'(prev_bv), 512'(1));
      out_m = out_m + (ar_fire ? 1 : 0) - (rl_fire ? 1 : 0);
      if (out_m > max_out_m) max_out_m = out_m;
      if (ar_fire) begin
        n_ar_acc++;
        check_eq("outstanding_limit", 512'(out_m <= 4), 512'(1));
        check_eq("ar_pending", 512'(exp_ar.size() != 0), 512'(1));
        e = (exp_ar.size() != 0) ? exp_ar.pop_front() : '0;
        check_eq("ar_payload", 512'({m_axi_araddr, m_axi_arlen, m_axi_arsize, m_axi_arburst}),
                 512'({e, 3'b101, 2'b01}));
      end
      prev_arv = m_axi_arvalid;
      prev_acc = ar_fire;
      prev_af  = almost_full;
      prev_bv  = back_valid;
      prev_pay = {m_axi_araddr, m_axi_arlen};
    end
  end

  task automatic run_job(input logic [32:0] a, input int len, input bit chk_launch);
    bit seen;
    push_exp(a, len);
    job_len = len;
    @(posedge hbm_clk); #1;
    addr_x = 64'(a);
    data_length = 32'(len);
    start = 1'b1;
    if (chk_launch) begin
      @(posedge hbm_clk); @(posedge hbm_clk); #1;
      check_eq("launch_arvalid_c1", 512'(m_axi_arvalid), 512'(0));
      @(posedge hbm_clk); #1;
      check_eq("launch_arvalid_c2", 512'(m_axi_arvalid), 512'(1));
    end
    seen = 0;
    for (int c = 0; c < 20000 && !seen; c++) begin
      @(negedge hbm_clk);
      if (done) seen = 1;
    end
    check_eq("done_seen", 512'(seen), 512'(1));
    check_eq("busy_low_at_done", 512'(busy), 512'(0));
    check_eq("words_left", 512'(exp_words.size()), 512'(0));
    check_eq("ars_left", 512'(exp_ar.size()), 512'(0));
    exp_words.delete();
    exp_ar.delete();
    @(posedge hbm_clk); #1;
    start = 1'b0;
    repeat (2) @(posedge hbm_clk);
  endtask

  task automatic check_reset_outputs(input string tag);
    check_eq({tag, "_ctrl"}, 512'({m_axi_arvalid, busy, done, error, back_valid}), 512'(0));
    check_eq({tag, "_ar"}, 512'({m_axi_araddr, m_axi_arlen}), 512'(0));
    check_eq({tag, "_data"}, back_data, 512'(0));
  endtask

  initial begin : watchdog
    #900000;
    $display("FAIL watchdog: simulation time limit reached");
    $display("[TB] %0d tests run, %0d failed", ntests, nfail + 1);
    $fatal(1, "watchdog");
  end

  initial begin : stim
    int base, acc;
    bit found;
    hbm_reset = 1'b1; start = 1'b0; addr_x = '0; data_length = '0;
    repeat (3) @(posedge hbm_clk);
    #1;
    check_reset_outputs("reset");
    hbm_reset = 1'b0;
    repeat (2) @(posedge hbm_clk);

    run_job(33'h1000, 64, 1);
    run_job(33'h0F00, 2048, 0);

    base = n_ar_acc;
    fork
      run_job(33'h4000, 2048, 0);
      begin
        found = 0;
        for (int c = 0; c < 1000 && !found; c++) begin
          @(negedge hbm_clk);
          if (m_axi_arvalid && m_axi_arready) found = 1;
        end
        @(posedge hbm_clk); #1;
        ar_block = 1'b1;
        af_force = 1'b1;
        repeat (10) @(posedge hbm_clk);
        #1 ar_block = 1'b0;
        repeat (40) @(posedge hbm_clk);
        #1 check_eq("ars_under_almost_full", 512'(n_ar_acc - base), 512'(2));
        af_force = 1'b0;
      end
    join

    r_delay = 100;
    max_out_m = 0;
    run_job(33'h2000, 2048, 0);
    check_eq("outstanding_saturates", 512'(max_out_m), 512'(4));
    r_delay = 0;

    err_addr = 33'h6020;
    run_job(33'h6000, 128, 0);
    check_eq("error_set", 512'(error), 512'(1));
    repeat (5) @(posedge hbm_clk);
    #1 check_eq("error_sticky", 512'(error), 512'(1));
    err_addr = '1;
    run_job(33'h7000, 64, 0);
    check_eq("error_cleared", 512'(error), 512'(0));

    run_job(33'h8000, 0, 0);

    push_exp(33'h5000, 2048);
    job_len = 2048;
    @(posedge hbm_clk); #1;
    addr_x = 64'h5000; data_length = 32'd2048; start = 1'b1;
    acc = 0;
    for (int c = 0; c < 1000 && acc < 2; c++) begin
      @(negedge hbm_clk);
      if (m_axi_arvalid && m_axi_arready) acc++;
    end
    check_eq("reset_job_ars", 512'(acc), 512'(2));
    @(posedge hbm_clk); #3;
    hbm_reset = 1'b1;
    #1 check_reset_outputs("async_reset");
    start = 1'b0;
    exp_words.delete();
    exp_ar.delete();
    repeat (3) @(posedge hbm_clk);
    #1 hbm_reset = 1'b0;
    repeat (2) @(posedge hbm_clk);
    run_job(33'h9000, 1024, 1);

    af_rand_en = 1'b1;
    for (int j = 0; j < 6; j++) begin
      ar_gap = $urandom_range(0, 50);
      r_gap  = $urandom_range(0, 50);
      run_job({15'd0, 12'($urandom_range(0, 4095)), 6'd0}, 64 * $urandom_range(1, 48), 0);
    end
    af_rand_en = 1'b0;

    $display("[TB] %0d tests run, %0d failed", ntests, nfail);
    $finish;
  end

endmodule
